uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_sampler.sv | 59 +++++
 rtl/uart_rx_param.sv | 133 +++++++++++++
 tb/tb_uart_rx_param.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, parity modes and the parity-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int PAR_MAX_W = 16;

  // Callers zero-extend narrower data; extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input int mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line synchroniser, per-bit timer and 3-sample majority vote around the bit centre.
module uart_bit_sampler #(
  parameter int CLKS_PER_BIT = 55
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic en,
  input  logic clr,
  output logic rxs,
  output logic bit_done,
  output logic bit_end,
  output logic bit_val
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);

  logic          meta;
  logic [CW-1:0] bit_cnt;
  logic          s0, s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      meta <= rx_in;
      rxs  <= meta;
    end
  end

  // Counter idles at 0, so the start-detect cycle is cycle 0 of the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  bit_cnt <= '0;
    else if (clr || !en || bit_cnt == CNT_LAST)  bit_cnt <= '0;
    else                                         bit_cnt <= bit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (en && bit_cnt == CNT_S0) s0 <= rxs;
      if (en && bit_cnt == CNT_S1) s1 <= rxs;
    end
  end

  // Third sample is the live rxs, so the vote resolves in the MID+1 cycle itself.
  assign bit_val  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign bit_done = en && (bit_cnt == CNT_VOTE);
  assign bit_end  = en && (bit_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, data shift register and parity/framing/break flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 55,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int IW      = $clog2(DATA_BITS) + 1;
  localparam bit HAS_PAR = (PARITY_MODE != PARITY_NONE);
  localparam logic [IW-1:0] DATA_END  = IW'(DATA_BITS);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  state_t               state;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err, frm_err;
  logic                 rxs, bit_done, bit_end, bit_val;
  logic                 en, clr, last_stop, brk;

  assign last_stop = (bit_idx == STOP_LAST);
  assign en  = (state == IDLE && !rxs) || state == START || state == DATA ||
               state == PARITY || state == STOP;
  assign clr = bit_done && ((state == START && bit_val) || (state == STOP && last_stop));
  assign brk = (shreg == '0) && !par_bit && !bit_val;

  uart_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .en       (en),
    .clr      (clr),
    .rxs      (rxs),
    .bit_done (bit_done),
    .bit_end  (bit_end),
    .bit_val  (bit_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      rx_byte       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (!rxs) begin
          state   <= START;
          rx_busy <= 1'b1;
          bit_idx <= '0;
          par_bit <= 1'b0;
          par_err <= 1'b0;
          frm_err <= 1'b0;
        end
        START: begin
          if (bit_done && bit_val) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (bit_end) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          if (bit_end && bit_idx == DATA_END) begin
            bit_idx <= '0;
            state   <= HAS_PAR ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_done) begin
            par_bit <= bit_val;
            par_err <= bit_val != parity_bit(PAR_MAX_W'(shreg), PARITY_MODE);
          end
          if (bit_end) state <= STOP;
        end
        STOP: if (bit_done) begin
          if (!last_stop) begin
            frm_err <= frm_err | ~bit_val;
            bit_idx <= bit_idx + IW'(1);
          end else begin
            // Leave mid-bit so a start edge right after the stop bit is not missed.
            rx_valid      <= 1'b1;
            rx_byte       <= shreg;
            rx_parity_err <= par_err;
            rx_frame_err  <= frm_err | ~bit_val;
            rx_break      <= brk;
            bit_idx       <= '0;
            if (!rxs && brk) begin
              state <= BREAK_WAIT;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        BREAK_WAIT: if (rxs) begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboarded bench for uart_rx_param: 8N1, 8E1 and 9N2 instances on one clock.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  // Two extra cycles cover the synchroniser between the pin edge and rxs.
  localparam int LAT0 = (1 + 8 + 0 + 1 - 1) * CPB + CPB / 2 + 2 + 2;
  localparam int LAT2 = (1 + 9 + 0 + 2 - 1) * CPB + CPB / 2 + 2 + 2;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } res_t;

  typedef struct packed {
    res_t r;
    int   cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_d = 1'b1, rx_p = 1'b1, rx_9 = 1'b1;
  logic [7:0] b_d, b_p;
  logic [8:0] b_9;
  logic v_d, pe_d, fe_d, bk_d, bz_d;
  logic v_p, pe_p, fe_p, bk_p, bz_p;
  logic v_9, pe_9, fe_9, bk_9, bz_9;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  res_t exp_q0[$], exp_q1[$], exp_q2[$];
  obs_t obs_q0[$], obs_q1[$], obs_q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_d), .rx_byte(b_d), .rx_valid(v_d),
    .rx_parity_err(pe_d), .rx_frame_err(fe_d), .rx_break(bk_d), .rx_busy(bz_d));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_par (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_p), .rx_byte(b_p), .rx_valid(v_p),
    .rx_parity_err(pe_p), .rx_frame_err(fe_p), .rx_break(bk_p), .rx_busy(bz_p));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(2)) u_9b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_9), .rx_byte(b_9), .rx_valid(v_9),
    .rx_parity_err(pe_9), .rx_frame_err(fe_9), .rx_break(bk_9), .rx_busy(bz_9));

  // One entry per sampled rx_valid cycle; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (v_d) obs_q0.push_back({1'b0, b_d, pe_d, fe_d, bk_d, cyc});
    if (v_p) obs_q1.push_back({1'b0, b_p, pe_p, fe_p, bk_p, cyc});
    if (v_9) obs_q2.push_back({b_9, pe_9, fe_9, bk_9, cyc});
  end

  task automatic set_line(input int inst, input logic v);
    case (inst)
      0:       rx_d = v;
      1:       rx_p = v;
      default: rx_9 = v;
    endcase
  endtask

  task automatic hold_bit(input int inst, input logic v);
    set_line(inst, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic push_exp(input int inst, input res_t e);
    case (inst)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int inst, output res_t e);
    e = '0;
    case (inst)
      0:       if (exp_q0.size() > 0) e = exp_q0.pop_front();
      1:       if (exp_q1.size() > 0) e = exp_q1.pop_front();
      default: if (exp_q2.size() > 0) e = exp_q2.pop_front();
    endcase
  endtask

  // Caller must be at a negedge; frames sent back to back get no idle gap.
  task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                            input logic stop_v, output int c0);
    int   db, pm, sb;
    res_t e;
    db = (inst == 2) ? 9 : 8;
    pm = (inst == 1) ? 2 : 0;
    sb = (inst == 2) ? 2 : 1;
    e.data = data;
    e.perr = (pm != 0) && (pbit != ((^data) ^ (pm == 1)));
    e.ferr = !stop_v;
    e.brk  = (data == 9'd0) && !pbit && !stop_v;
    push_exp(inst, e);
    c0 = cyc;
    hold_bit(inst, 1'b0);
    for (int i = 0; i < db; i++) hold_bit(inst, data[i]);
    if (pm != 0) hold_bit(inst, pbit);
    for (int s = 0; s < sb; s++) hold_bit(inst, (s == sb - 1) ? stop_v : 1'b1);
    set_line(inst, 1'b1);
  endtask

  task automatic wait_obs(input int inst, input int limit, output obs_t o, output bit got);
    got = 1'b0;
    o   = '0;
    for (int i = 0; i <= limit && !got; i++) begin
      case (inst)
        0:       if (obs_q0.size() > 0) begin o = obs_q0.pop_front(); got = 1'b1; end
        1:       if (obs_q1.size() > 0) begin o = obs_q1.pop_front(); got = 1'b1; end
        default: if (obs_q2.size() > 0) begin o = obs_q2.pop_front(); got = 1'b1; end
      endcase
      if (!got) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({b_d, v_d, pe_d, fe_d, bk_d, bz_d} !== 13'd0)
      $display("FAIL reset_def: got %h want 0", {b_d, v_d, pe_d, fe_d, bk_d, bz_d});
    else passed++;
    checks++;
    if ({b_p, v_p, pe_p, fe_p, bk_p, bz_p} !== 13'd0)
      $display("FAIL reset_par: got %h want 0", {b_p, v_p, pe_p, fe_p, bk_p, bz_p});
    else passed++;
    checks++;
    if ({b_9, v_9, pe_9, fe_9, bk_9, bz_9} !== 14'd0)
      $display("FAIL reset_9b: got %h want 0", {b_9, v_9, pe_9, fe_9, bk_9, bz_9});
    else passed++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int c0; obs_t o; bit got; res_t e;
    send_frame(0, 9'h0A5, 1'b0, 1'b1, c0);
    wait_obs(0, 4 * CPB, o, got);
    pop_exp(0, e);
    checks++;
    if (!got) $display("FAIL basic_valid: no rx_valid within bound");
    else if (o.r !== e) $display("FAIL basic_data: got %h want %h", o.r, e);
    else passed++;
    checks++;
    if (!got || (o.cyc - c0) != LAT0)
      $display("FAIL basic_latency: got %0d want %0d", o.cyc - c0, LAT0);
    else passed++;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (obs_q0.size() != 0) $display("FAIL basic_single_pulse: extra strobes %0d want 0", obs_q0.size());
    else passed++;
  endtask

  task automatic test_parity;
    int c0; obs_t o; bit got; res_t e;
    send_frame(1, 9'h003, 1'b1, 1'b1, c0);
    wait_obs(1, 4 * CPB, o, got);
    pop_exp(1, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL parity_bad: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
    repeat (CPB) @(negedge clk);
    send_frame(1, 9'h003, 1'b0, 1'b1, c0);
    wait_obs(1, 4 * CPB, o, got);
    pop_exp(1, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL parity_good: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
  endtask

  task automatic test_false_start;
    int c0; obs_t o; bit got; res_t e;
    set_line(0, 1'b0);
    repeat (4) @(negedge clk);
    set_line(0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (obs_q0.size() != 0) $display("FAIL glitch_no_valid: strobes %0d want 0", obs_q0.size());
    else passed++;
    checks++;
    if ({b_d, pe_d, fe_d, bk_d, bz_d} !== {8'hA5, 4'b0000})
      $display("FAIL glitch_hold: got %h want %h", {b_d, pe_d, fe_d, bk_d, bz_d}, {8'hA5, 4'b0000});
    else passed++;
    send_frame(0, 9'h03C, 1'b0, 1'b1, c0);
    wait_obs(0, 4 * CPB, o, got);
    pop_exp(0, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL after_glitch: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
  endtask

  task automatic test_frame_err;
    int c0; obs_t o; bit got; res_t e;
    repeat (CPB) @(negedge clk);
    send_frame(0, 9'h081, 1'b0, 1'b0, c0);
    wait_obs(0, 4 * CPB, o, got);
    pop_exp(0, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL frame_err: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (obs_q0.size() != 0 || bz_d !== 1'b0)
      $display("FAIL frame_err_recover: strobes %0d busy %b want 0 0", obs_q0.size(), bz_d);
    else passed++;
  endtask

  task automatic test_break;
    int c0; obs_t o; bit got; res_t e;
    push_exp(0, '{data: 9'd0, perr: 1'b0, ferr: 1'b1, brk: 1'b1});
    set_line(0, 1'b0);
    repeat (3 * 10 * CPB) @(negedge clk);
    checks++;
    if (bz_d !== 1'b1) $display("FAIL break_busy: got %b want 1", bz_d);
    else passed++;
    wait_obs(0, 1, o, got);
    pop_exp(0, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL break_flags: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
    set_line(0, 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q0.size() != 0 || bz_d !== 1'b0)
      $display("FAIL break_release: strobes %0d busy %b want 0 0", obs_q0.size(), bz_d);
    else passed++;
    send_frame(0, 9'h055, 1'b0, 1'b1, c0);
    wait_obs(0, 4 * CPB, o, got);
    pop_exp(0, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL after_break: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int c0, c1; obs_t o; bit got; res_t e;
    send_frame(2, 9'h1FF, 1'b0, 1'b1, c0);
    send_frame(2, 9'h100, 1'b0, 1'b1, c1);
    wait_obs(2, 4 * CPB, o, got);
    pop_exp(2, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL b2b_first: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
    checks++;
    if (!got || (o.cyc - c0) != LAT2)
      $display("FAIL b2b_latency: got %0d want %0d", o.cyc - c0, LAT2);
    else passed++;
    wait_obs(2, 4 * CPB, o, got);
    pop_exp(2, e);
    checks++;
    if (!got || o.r !== e) $display("FAIL b2b_second: got %h want %h (strobe %0b)", o.r, e, got);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    repeat (CPB) @(negedge clk);
    hold_bit(2, 1'b0);
    hold_bit(2, 1'b1);
    hold_bit(2, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b_9, v_9, pe_9, fe_9, bk_9, bz_9} !== 14'd0)
      $display("FAIL midreset_outputs: got %h want 0", {b_9, v_9, pe_9, fe_9, bk_9, bz_9});
    else passed++;
    repeat (3) @(negedge clk);
    set_line(2, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (14 * CPB) @(negedge clk);
    checks++;
    if (obs_q2.size() != 0 || bz_9 !== 1'b0)
      $display("FAIL midreset_no_valid: strobes %0d busy %b want 0 0", obs_q2.size(), bz_9);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_frame_err();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
